// File: rtl/pcie_os_gen.sv
// PCIe Gen1/Gen2 transmit ordered-set generator and symbol multiplexer.
// Periodic SKP scheduling is compiled in only when PCIE_OS_GEN_SKP_EN is defined.
module pcie_os_gen #(
    parameter int LANES        = 4,
    parameter int SKP_INTERVAL = 1180
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [LANES-1:0]     in_k,
    input  logic                 in_last,
    input  logic                 os_req_valid,
    input  logic [1:0]           os_req_type,
    input  logic [7:0]           os_req_num,
    output logic                 os_req_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [LANES-1:0]     out_k,
    output logic                 out_eidle
);

    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_SKP = 8'h1C;
    localparam logic [7:0] K_FTS = 8'h3C;
    localparam logic [7:0] K_IDL = 8'h7C;
    localparam logic [7:0] K_EIE = 8'hFC;
    localparam logic [7:0] D10_2 = 8'h4A;

    typedef enum logic [1:0] {ST_IDLE, ST_PKT, ST_OS, ST_EIDLE} state_t;
    // Low three values match the os_req_type encoding so requests cast directly.
    typedef enum logic [1:0] {OS_FTS, OS_EIOS, OS_EIEOS, OS_SKP} os_kind_t;

    state_t               state, state_d;
    os_kind_t             os_kind, kind_d, start_kind;
    logic [3:0]           sym_idx, idx_d;
    logic [7:0]           fts_left, fts_d;
    logic [8*LANES-1:0]   data_d;
    logic [LANES-1:0]     k_d;
    logic                 eidle_d;
    logic                 start_os;
    logic                 skp_done;
    logic [1:0]           skp_pend;
    logic [8:0]           os_cur;

    function automatic logic [8:0] os_sym(os_kind_t kind, logic [3:0] idx);
        logic [8:0] s;
        s = {1'b1, K_COM};
        if (idx != 4'd0) begin
            unique case (kind)
                OS_SKP:   s = {1'b1, K_SKP};
                OS_FTS:   s = {1'b1, K_FTS};
                OS_EIOS:  s = {1'b1, K_IDL};
                OS_EIEOS: s = (idx == 4'd15) ? {1'b0, D10_2} : {1'b1, K_EIE};
            endcase
        end
        return s;
    endfunction

    assign os_cur = os_sym(os_kind, sym_idx);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d      = state;
        kind_d       = os_kind;
        idx_d        = sym_idx;
        fts_d        = fts_left;
        data_d       = '0;
        k_d          = '0;
        eidle_d      = 1'b0;
        in_ready     = 1'b0;
        os_req_ready = 1'b0;
        skp_done     = 1'b0;
        start_os     = 1'b0;
        start_kind   = OS_SKP;

        unique case (state)
            ST_IDLE: begin
                if (skp_pend != 2'd0) begin
                    start_os = 1'b1;
                end else if (os_req_valid) begin
                    os_req_ready = 1'b1;
                    if (os_req_type != 2'd3) begin
                        start_os   = 1'b1;
                        start_kind = os_kind_t'(os_req_type);
                    end
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        data_d = in_data;
                        k_d    = in_k;
                        if (!in_last) state_d = ST_PKT;
                    end
                end
            end
            ST_PKT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d = in_data;
                    k_d    = in_k;
                    if (in_last) state_d = ST_IDLE;
                end
            end
            ST_OS: begin
                data_d = {LANES{os_cur[7:0]}};
                k_d    = {LANES{os_cur[8]}};
                if (sym_idx == ((os_kind == OS_EIEOS) ? 4'd15 : 4'd3)) begin
                    if (os_kind == OS_FTS && fts_left > 8'd1) begin
                        fts_d = fts_left - 8'd1;
                        idx_d = 4'd0;
                    end else begin
                        state_d  = (os_kind == OS_EIOS) ? ST_EIDLE : ST_IDLE;
                        skp_done = (os_kind == OS_SKP);
                    end
                end else begin
                    idx_d = sym_idx + 4'd1;
                end
            end
            ST_EIDLE: begin
                eidle_d = 1'b1;
                if (os_req_valid) begin
                    os_req_ready = 1'b1;
                    // Only FTS and EIEOS wake the link; EIOS and reserved are swallowed.
                    if (os_req_type == 2'd0 || os_req_type == 2'd2) begin
                        start_os   = 1'b1;
                        start_kind = os_kind_t'(os_req_type);
                        eidle_d    = 1'b0;
                    end
                end
            end
        endcase

        if (start_os) begin
            data_d  = {LANES{K_COM}};
            k_d     = '1;
            state_d = ST_OS;
            kind_d  = start_kind;
            idx_d   = 4'd1;
            fts_d   = (os_req_num == 8'd0) ? 8'd1 : os_req_num;
        end

        if (rst) begin
            in_ready     = 1'b0;
            os_req_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state     <= ST_IDLE;
            os_kind   <= OS_SKP;
            sym_idx   <= 4'd0;
            fts_left  <= 8'd0;
            out_data  <= '0;
            out_k     <= '0;
            out_eidle <= 1'b0;
        end else begin
            state     <= state_d;
            os_kind   <= kind_d;
            sym_idx   <= idx_d;
            fts_left  <= fts_d;
            out_data  <= data_d;
            out_k     <= k_d;
            out_eidle <= eidle_d;
        end
    end

`ifdef PCIE_OS_GEN_SKP_EN
    localparam int CW = $clog2(SKP_INTERVAL);

    logic [CW-1:0] skp_cnt;
    logic          skp_wrap;

    assign skp_wrap = (state != ST_EIDLE) && (skp_cnt == CW'(SKP_INTERVAL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            skp_cnt  <= '0;
            skp_pend <= 2'd0;
        end else begin
            if (state == ST_EIDLE || skp_wrap) skp_cnt <= '0;
            else                               skp_cnt <= skp_cnt + CW'(1);
            if (skp_wrap && !skp_done) begin
                if (skp_pend != 2'd3) skp_pend <= skp_pend + 2'd1;
            end else if (skp_done && !skp_wrap) begin
                skp_pend <= skp_pend - 2'd1;
            end
        end
    end
`else
    logic unused_skp;

    assign skp_pend   = 2'd0;
    assign unused_skp = skp_done | (SKP_INTERVAL < 16);
`endif

endmodule

// File: tb/tb_pcie_os_gen.sv
// Randomised self-checking bench for pcie_os_gen against a queue-based symbol model.
// Follows PCIE_OS_GEN_SKP_EN so the model schedules SKP only when the RTL does.
module tb_pcie_os_gen;

    localparam int LANES   = 4;
    localparam int SKP_INT = 16;
    localparam int W       = 8 * LANES;

`ifdef PCIE_OS_GEN_SKP_EN
    localparam bit SKP_ON = 1'b1;
`else
    localparam bit SKP_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_data = '0;
    logic [LANES-1:0] in_k = '0;
    logic             in_last = 1'b0;
    logic             os_req_valid = 1'b0;
    logic [1:0]       os_req_type = 2'd0;
    logic [7:0]       os_req_num = 8'd0;
    logic             os_req_ready;
    logic [W-1:0]     out_data;
    logic [LANES-1:0] out_k;
    logic             out_eidle;

    always #5 clk = ~clk;

    pcie_os_gen #(.LANES(LANES), .SKP_INTERVAL(SKP_INT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_k(in_k), .in_last(in_last),
        .os_req_valid(os_req_valid), .os_req_type(os_req_type),
        .os_req_num(os_req_num), .os_req_ready(os_req_ready),
        .out_data(out_data), .out_k(out_k), .out_eidle(out_eidle)
    );

    // act: 1 = completes a SKP OS, 2 = completes an EIOS (enter electrical idle)
    typedef struct packed {
        logic       k;
        logic [7:0] b;
        logic [1:0] act;
    } sym_t;

    sym_t             m_q[$];
    bit               m_pkt, m_eidle, m_rdy, m_ordy;
    int               m_cnt, m_pend;
    logic [W-1:0]     exp_d;
    logic [LANES-1:0] exp_k;
    logic             exp_e;

    int errors = 0, checks = 0;
    int skp_seen = 0, skp_expected = 0;

    int               pkt_left = 0, beat_idx = 0;
    logic [W-1:0]     cur_d = '0;
    logic [LANES-1:0] cur_k = '0;
    bit               cur_last = 1'b0;
    bit               req_on = 1'b0;
    logic [1:0]       req_t = 2'd0;
    logic [7:0]       req_n = 8'd0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pkt = 0; m_eidle = 0; m_cnt = 0; m_pend = 0;
        exp_d = '0; exp_k = '0; exp_e = 1'b0;
    endtask

    // kind: 0 FTS, 1 EIOS, 2 EIEOS, 3 SKP
    task automatic push_os(int kind, int n);
        int reps = (kind == 0) ? n : 1;
        int len  = (kind == 2) ? 16 : 4;
        sym_t s;
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < len; i++) begin
                s.k = 1'b1; s.act = 2'd0;
                if (i == 0) s.b = 8'hBC;
                else begin
                    case (kind)
                        0: s.b = 8'h3C;
                        1: s.b = 8'h7C;
                        3: s.b = 8'h1C;
                        default: begin
                            s.b = (i == 15) ? 8'h4A : 8'hFC;
                            s.k = (i != 15);
                        end
                    endcase
                end
                if (r == reps - 1 && i == len - 1)
                    s.act = (kind == 3) ? 2'd1 : (kind == 1) ? 2'd2 : 2'd0;
                m_q.push_back(s);
            end
        end
    endtask

    function automatic int count_skp(logic [W-1:0] d, logic [LANES-1:0] k);
        int c = 0;
        for (int l = 0; l < LANES; l++)
            if (k[l] && d[8*l +: 8] == 8'h1C) c++;
        return c;
    endfunction

    task automatic tick(bit r, bit iv, logic [W-1:0] id, logic [LANES-1:0] ik, bit il,
                        bit rv, logic [1:0] rt, logic [7:0] rn);
        bit   was_e, wrap, done;
        sym_t s;
        @(negedge clk);
        check("out_data", out_data, exp_d);
        check("out_k", out_k, exp_k);
        check("out_eidle", out_eidle, exp_e);
        skp_seen     += count_skp(out_data, out_k);
        skp_expected += count_skp(exp_d, exp_k);

        rst = r; in_valid = iv; in_data = id; in_k = ik; in_last = il;
        os_req_valid = rv; os_req_type = rt; os_req_num = rn;
        #1;
        m_rdy = 0; m_ordy = 0;
        if (!r && m_q.size() == 0) begin
            if (m_eidle)          m_ordy = rv;
            else if (m_pkt)       m_rdy = 1;
            else if (m_pend > 0)  m_rdy = 0;
            else if (rv)          m_ordy = 1;
            else                  m_rdy = 1;
        end
        check("in_ready", in_ready, m_rdy);
        check("os_req_ready", os_req_ready, m_ordy);

        if (r) begin
            model_reset();
        end else begin
            was_e = m_eidle;
            wrap  = SKP_ON && !was_e && (m_cnt == SKP_INT - 1);
            done  = 0;
            if (m_q.size() == 0) begin
                if (m_eidle) begin
                    if (m_ordy && (rt == 2'd0 || rt == 2'd2)) begin
                        push_os(int'(rt), (rn == 0) ? 1 : int'(rn));
                        m_eidle = 0;
                    end
                end else if (!m_pkt && m_pend > 0) begin
                    push_os(3, 1);
                end else if (m_ordy && rt != 2'd3) begin
                    push_os(int'(rt), (rn == 0) ? 1 : int'(rn));
                end
            end
            if (m_q.size() > 0) begin
                s = m_q.pop_front();
                exp_d = {LANES{s.b}}; exp_k = {LANES{s.k}}; exp_e = 1'b0;
                if (s.act == 2'd1) done = 1;
                if (s.act == 2'd2) m_eidle = 1;
            end else if (m_eidle) begin
                exp_d = '0; exp_k = '0; exp_e = 1'b1;
            end else if (m_rdy && iv) begin
                exp_d = id; exp_k = ik; exp_e = 1'b0;
                m_pkt = !il;
            end else begin
                exp_d = '0; exp_k = '0; exp_e = 1'b0;
            end
            if (SKP_ON) begin
                m_cnt = (was_e || wrap) ? 0 : m_cnt + 1;
                if (wrap && !done) begin
                    if (m_pend < 3) m_pend++;
                end else if (done && !wrap) begin
                    m_pend--;
                end
            end
        end
    endtask

    task automatic gen_beat();
        cur_d = {$urandom, $urandom};
        cur_k = '0;
        cur_last = (pkt_left == 1);
        if (beat_idx == 0) begin cur_d[7:0] = 8'hFB; cur_k[0] = 1'b1; end
        if (cur_last) begin cur_d[W-1 -: 8] = 8'hFD; cur_k[LANES-1] = 1'b1; end
    endtask

    task automatic start_pkt(int n);
        pkt_left = n; beat_idx = 0;
        gen_beat();
    endtask

    task automatic start_req(logic [1:0] t, logic [7:0] n);
        req_on = 1'b1; req_t = t; req_n = n;
    endtask

    task automatic step(bit r);
        bit iv;
        iv = (pkt_left > 0);
        tick(r, iv, cur_d, cur_k, cur_last, req_on, req_t, req_n);
        if (!r && m_rdy && iv) begin
            pkt_left--; beat_idx++;
            if (pkt_left > 0) gen_beat();
        end
        if (!r && m_ordy) req_on = 1'b0;
    endtask

    task automatic wait_req(string tag, int bound);
        int n = 0;
        while (req_on && n < bound) begin step(0); n++; end
        check(tag, req_on, 1'b0);
    endtask

    task automatic wait_quiet(string tag, int bound);
        int n = 0;
        while ((pkt_left > 0 || m_pkt || m_q.size() > 0) && n < bound) begin step(0); n++; end
        check(tag, n < bound, 1'b1);
    endtask

    initial begin
        int n;
        model_reset();
        repeat (2) @(posedge clk);
        repeat (3) step(1);

        repeat (40) step(0);

        start_pkt(40);
        wait_quiet("pkt40_done", 200);
        repeat (6) step(0);

        start_req(2'd0, 8'd3);
        wait_req("fts3_accept", 50);
        repeat (16) step(0);
        start_req(2'd0, 8'd0);
        wait_req("fts0_accept", 50);
        repeat (8) step(0);

        start_req(2'd1, 8'd0);
        wait_req("eios_accept", 50);
        repeat (6) step(0);
        start_pkt(3);
        repeat (50) step(0);
        start_req(2'd1, 8'd0);
        wait_req("eios_in_eidle", 5);
        start_req(2'd3, 8'd0);
        wait_req("rsvd_in_eidle", 5);
        repeat (4) step(0);
        start_req(2'd2, 8'd0);
        wait_req("eieos_accept", 5);
        wait_quiet("eieos_done", 100);

        n = 0;
        while (m_pend == 0 && n < 40) begin step(0); n++; end
        start_req(2'd0, 8'd1);
        wait_req("req_after_wrap", 50);
        repeat (10) step(0);
        start_req(2'd3, 8'd0);
        wait_req("rsvd_idle", 20);
        repeat (4) step(0);

        start_req(2'd0, 8'd4);
        wait_req("fts4_accept", 50);
        repeat (5) step(0);
        step(1);
        repeat (20) step(0);

        for (int c = 0; c < 3000; c++) begin
            if (pkt_left == 0 && $urandom_range(0, 99) < 20) start_pkt($urandom_range(1, 6));
            if (!req_on && $urandom_range(0, 99) < 4)
                start_req(2'($urandom_range(0, 3)),
                          ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 4)));
            step(0);
        end
        req_on = 1'b0;
        start_req(2'd2, 8'd0);
        wait_req("final_wake", 1100);
        wait_quiet("final_drain", 1100);

        repeat (5000) step(0);
        check("skp_symbol_count", skp_seen, skp_expected);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pcie_os_gen.md
# pcie_os_gen

Ordered-set generator and symbol-stream multiplexer for the PCIe Gen1/Gen2 physical-layer transmit path. It sits between the framed TLP/DLLP symbol stream and the 8b/10b encoders, one symbol per lane per cycle, across a parametrised lane count. It emits SKP ordered sets periodically and FTS, EIOS and EIEOS ordered sets on request, only at packet boundaries. When there is nothing to send it drives logical idle, or electrical idle after an EIOS.

## Interface
- LANES, 4, lane count (1, 2, 4, 8, 16); symbol byte i belongs to lane i.
- SKP_INTERVAL, 1180, symbol times between SKP schedule events (≥ 16).
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  symbol clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  upstream beat accepted when in_valid && in_ready.
- in_data  in  8*LANES  framed symbols (STP=0xFB, SDP=0x5C, END=0xFD, EDB=0xFE, PAD=0xF7 when the matching K bit is set).
- in_k  in  LANES  per-lane K flag.
- in_last  in  1  beat is the final beat of a packet.
- os_req_valid  in  1  ordered-set request.
- os_req_type  in  2  0=FTS, 1=EIOS, 2=EIEOS, 3=reserved (treated as no-op: accepted, nothing sent).
- os_req_num  in  8  FTS count for type 0; value 0 is treated as 1.
- os_req_ready  out  1  one-cycle pulse when the request is accepted.
- out_data  out  8*LANES  symbols to the encoders.
- out_k  out  LANES  per-lane K flag.
- out_eidle  out  1  transmitter in electrical idle.

## Operation
- K codes: COM=0xBC, SKP=0x1C, FTS=0x3C, IDL=0x7C, EIE=0xFC. Logical idle is 0x00 with k=0.
- Every ordered-set symbol is replicated on all lanes.
- Ordered sets:
  - SKP OS = COM, SKP, SKP, SKP.
  - FTS OS = COM, FTS, FTS, FTS, sent os_req_num times back to back.
  - EIOS = COM, IDL, IDL, IDL.
  - EIEOS = COM, 14×EIE, 0x4A (D10.2, k=0).
- States:
  - IDLE: logical idle output.
  - PKT: inside a packet. Entered on an accepted beat with in_last=0; left on an accepted beat with in_last=1.
  - OS: ordered set in progress. Uses a symbol index counter and an FTS repeat counter.
  - EIDLE: electrical idle.
- SKP scheduler: a symbol counter counts 0..SKP_INTERVAL-1 in all states except EIDLE, where it is held at 0. On wrap it increments skp_pend, which saturates at 3. Each completed SKP OS decrements skp_pend.
- Selection at each boundary (IDLE, end of an OS, or after the in_last beat), in priority order:
  - skp_pend>0 → SKP OS.
  - os_req_valid → requested OS; os_req_ready pulses that cycle.
  - in_valid → data.
  - otherwise → logical idle.
- in_ready=1 only in IDLE/PKT when skp_pend=0 and os_req_valid=0. In PKT, in_ready=1 regardless of skp_pend or os_req_valid; SKP and requests are deferred until the packet ends.
- After the last EIOS symbol the block enters EIDLE:
  - out_eidle=1, out_data=0, out_k=0, in_ready=0.
  - Only an os_req of FTS or EIEOS is accepted. out_eidle drops in the same cycle that OS's first symbol (COM) is driven.
  - An EIOS request in EIDLE is accepted and ignored.
- Reserved type: os_req_ready pulses and the block stays in its current state.

## Timing
- Outputs are registered, with 1-cycle latency from the accepted beat or request to its first symbol on out_data.
- Reset values:
  - out_data=0, out_k=0, out_eidle=0, in_ready=0, os_req_ready=0.
  - State IDLE, skp_pend=0, symbol counter=0.
  - in_ready goes high the first cycle after rst deasserts.
- An ordered set is never interrupted. Mid-OS request or data waits.
- Back-to-back: the next OS or data beat follows the final OS symbol with no gap cycle.
- A SKP wrap coinciding with a decrement leaves skp_pend unchanged.
- rst asserted mid-OS or mid-packet aborts immediately; the next cycle shows reset values.

## Configuration
- PCIE_OS_GEN_SKP_EN defined: periodic SKP scheduling as described.
- PCIE_OS_GEN_SKP_EN undefined:
  - Scheduler and skp_pend are removed; skp_pend is treated as constant 0.
  - SKP OS is never emitted.
  - This is for common-clock simulation and loopback.

## Test plan
- LANES=4, SKP_INTERVAL=16, no traffic → 0x00 idle, then COM,SKP,SKP,SKP (k=1 on all lanes) every 16 cycles, starting at cycle 17 after reset release.
- 40-beat packet (STP…END) spanning a SKP wrap → packet uninterrupted; SKP OS starts the cycle after the in_last beat; in_ready=0 during the SKP.
- os_req FTS, num=3 → 12 cycles: COM,FTS,FTS,FTS ×3; os_req_ready pulses exactly once.
- EIOS request → COM,IDL,IDL,IDL, then out_eidle=1 and in_ready=0 with in_valid held high for 50 cycles, with no SKP emitted. Then an EIEOS request → COM, 14×0xFC, 0x4A(k=0); out_eidle=0 from the COM cycle.
- os_req_valid and a SKP wrap in the same IDLE cycle → SKP OS first, then the requested OS with no gap.
- Without PCIE_OS_GEN_SKP_EN, 5000 idle cycles → no 0x1C symbol observed; rst pulsed mid-FTS → next cycle out_data=0, out_k=0.
